// File: rtl/stack_seq_pkg.sv
// Shared types and encodings for the call/return/interrupt stack sequencer.
package stack_seq_pkg;

  // Sequencer FSM states: one push or pop per stack state, then DONE.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_HI = 3'd1,
    S_PUSH_LO = 3'd2,
    S_PUSH_FL = 3'd3,
    S_POP_FL  = 3'd4,
    S_POP_LO  = 3'd5,
    S_POP_HI  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Operation latched at accept; it selects the sequence and the DONE pulses.
  typedef enum logic [1:0] {
    OP_CALL = 2'd0,
    OP_RET  = 2'd1,
    OP_RTI  = 2'd2,
    OP_INT  = 2'd3
  } op_t;

  // Memory-stage write source select.
  localparam logic [1:0] WSRC_FLAGS = 2'b00;
  localparam logic [1:0] WSRC_PC_HI = 2'b01;
  localparam logic [1:0] WSRC_PC_LO = 2'b10;
  localparam logic [1:0] WSRC_REG   = 2'b11;

  // Memory-stage address select.
  localparam logic [1:0] ASEL_STD = 2'b00;
  localparam logic [1:0] ASEL_LDD = 2'b01;
  localparam logic [1:0] ASEL_SP  = 2'b10;

  // First stack state of each operation's sequence.
  function automatic state_t first_state(input op_t op);
    case (op)
      OP_INT, OP_CALL: first_state = S_PUSH_HI;
      OP_RTI:          first_state = S_POP_FL;
      default:         first_state = S_POP_LO;
    endcase
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: turns call/ret/rti/interrupt requests into a fixed series
// of one-cycle stack pushes/pops on the memory stage while stalling the front
// end. Pushes save PC high, PC low, then flags (interrupt only); pops restore
// in the reverse order. SP itself lives in the memory stage.
module stack_sequencer
  import stack_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        rti_req,
  input  logic [31:0] pc_in,
  input  logic [2:0]  flags_in,
  input  logic [15:0] mem_data,
  output logic        memory_read,
  output logic        memory_write,
  output logic        memory_push,
  output logic        memory_pop,
  output logic [1:0]  memory_address_select,
  output logic [1:0]  memory_write_src_select,
  output logic [31:0] saved_pc,
  output logic [2:0]  saved_flags,
  output logic        ack,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic [2:0]  flags_out,
  output logic        flags_valid,
  output logic        vector_load
);

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  op_t         w_op_sel;
  logic        r_int_pending;
  logic [31:0] r_saved_pc;
  logic [2:0]  r_saved_flags;
  logic [31:0] r_pc_out;
  logic [2:0]  r_flags_out;

  logic        w_any_int;
  logic        w_accept;
  logic        w_rd, w_wr, w_push, w_pop;
  logic [1:0]  w_asel, w_wsrc;
  logic        w_pc_valid, w_flags_valid, w_vector_load;

  // Request arbitration: only IDLE accepts; a pending interrupt ranks with a live one.
  always_comb begin
    w_any_int = interrupt | r_int_pending;
    w_accept  = (r_state == S_IDLE) & (w_any_int | rti_req | ret_req | call_req);
    if (w_any_int)    w_op_sel = OP_INT;
    else if (rti_req) w_op_sel = OP_RTI;
    else if (ret_req) w_op_sel = OP_RET;
    else              w_op_sel = OP_CALL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-state memory controls / completion pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd          = 1'b0;
    w_wr          = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_asel        = ASEL_STD;
    w_wsrc        = WSRC_FLAGS;
    w_pc_valid    = 1'b0;
    w_flags_valid = 1'b0;
    w_vector_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = first_state(w_op_sel);
      end
      S_PUSH_HI: begin
        w_wr        = 1'b1;
        w_push      = 1'b1;
        w_asel      = ASEL_SP;
        w_wsrc      = WSRC_PC_HI;
        w_state_nxt = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        w_wr        = 1'b1;
        w_push      = 1'b1;
        w_asel      = ASEL_SP;
        w_wsrc      = WSRC_PC_LO;
        // Only an interrupt also saves the flags word.
        w_state_nxt = (r_op == OP_INT) ? S_PUSH_FL : S_DONE;
      end
      S_PUSH_FL: begin
        w_wr        = 1'b1;
        w_push      = 1'b1;
        w_asel      = ASEL_SP;
        w_wsrc      = WSRC_FLAGS;
        w_state_nxt = S_DONE;
      end
      S_POP_FL: begin
        w_rd        = 1'b1;
        w_pop       = 1'b1;
        w_asel      = ASEL_SP;
        w_state_nxt = S_POP_LO;
      end
      S_POP_LO: begin
        w_rd        = 1'b1;
        w_pop       = 1'b1;
        w_asel      = ASEL_SP;
        w_state_nxt = S_POP_HI;
      end
      S_POP_HI: begin
        w_rd        = 1'b1;
        w_pop       = 1'b1;
        w_asel      = ASEL_SP;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // A call's target PC comes from EX, so it raises nothing here.
        w_pc_valid    = (r_op == OP_RET) | (r_op == OP_RTI);
        w_flags_valid = (r_op == OP_RTI);
        w_vector_load = (r_op == OP_INT);
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture return context and operation at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_saved_pc    <= 32'h0;
      r_saved_flags <= 3'h0;
      r_op          <= OP_CALL;
    end else if (w_accept) begin
      r_saved_pc    <= pc_in;
      r_saved_flags <= flags_in;
      r_op          <= w_op_sel;
    end
  end

  // Remember an interrupt that arrives while busy; clear it when serviced.
  always_ff @(posedge clk) begin
    if (reset)                               r_int_pending <= 1'b0;
    else if (w_accept && w_op_sel == OP_INT) r_int_pending <= 1'b0;
    else if (interrupt)                      r_int_pending <= 1'b1;
  end

  // Load popped words at the edge that ends each pop state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_out    <= 32'h0;
      r_flags_out <= 3'h0;
    end else begin
      case (r_state)
        S_POP_LO: r_pc_out[15:0]  <= mem_data;
        S_POP_HI: r_pc_out[31:16] <= mem_data;
        S_POP_FL: r_flags_out     <= mem_data[2:0];
        default:  ;
      endcase
    end
  end

  // Every output is forced low while reset is held, including registered ones
  // that have not yet seen the reset edge.
  assign ack                     = ~reset & w_accept;
  assign stall                   = ~reset & (w_accept | (r_state != S_IDLE));
  assign memory_read             = ~reset & w_rd;
  assign memory_write            = ~reset & w_wr;
  assign memory_push             = ~reset & w_push;
  assign memory_pop              = ~reset & w_pop;
  assign memory_address_select   = reset ? 2'b00 : w_asel;
  assign memory_write_src_select = reset ? 2'b00 : w_wsrc;
  assign saved_pc                = reset ? 32'h0 : r_saved_pc;
  assign saved_flags             = reset ? 3'h0  : r_saved_flags;
  assign pc_out                  = reset ? 32'h0 : r_pc_out;
  assign flags_out               = reset ? 3'h0  : r_flags_out;
  assign pc_valid                = ~reset & w_pc_valid;
  assign flags_valid             = ~reset & w_flags_valid;
  assign vector_load             = ~reset & w_vector_load;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a memory-stage stack model (array + SP starting
// at 1024) serves pops and records pushes; each transaction's expectations
// come from the operation's rules (which words go on/come off the stack, how
// long the stall lasts, which pulse ends it).
module tb_stack_sequencer;

  localparam int K_CALL = 0;
  localparam int K_RET  = 1;
  localparam int K_RTI  = 2;
  localparam int K_INT  = 3;

  logic        clk = 1'b0;
  logic        reset, interrupt, call_req, ret_req, rti_req;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [15:0] mem_data;
  logic        memory_read, memory_write, memory_push, memory_pop;
  logic [1:0]  memory_address_select, memory_write_src_select;
  logic [31:0] saved_pc;
  logic [2:0]  saved_flags;
  logic        ack, stall;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  flags_out;
  logic        flags_valid, vector_load;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .call_req(call_req), .ret_req(ret_req), .rti_req(rti_req),
    .pc_in(pc_in), .flags_in(flags_in), .mem_data(mem_data),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .saved_pc(saved_pc), .saved_flags(saved_flags),
    .ack(ack), .stall(stall), .pc_out(pc_out), .pc_valid(pc_valid),
    .flags_out(flags_out), .flags_valid(flags_valid), .vector_load(vector_load)
  );

  // Memory-stage model: push writes at SP then decrements; pop increments and
  // the read word is the one just above SP.
  logic [15:0] stk [0:2047];
  logic [10:0] sp;
  logic [15:0] pushed_q[$];
  logic [15:0] wdata;

  assign mem_data = memory_read ? stk[sp + 11'd1] : 16'h0;

  always_comb begin
    wdata = 16'h0;
    case (memory_write_src_select)
      2'b00:   wdata = {13'h0, saved_flags};
      2'b01:   wdata = saved_pc[31:16];
      2'b10:   wdata = saved_pc[15:0];
      default: wdata = 16'h0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic        s_ack, s_stall, s_rd, s_wr, s_push, s_pop, s_pcv, s_flv, s_vl;
  logic [1:0]  s_asel, s_wsrc;
  logic [31:0] s_spc, s_pcout;
  logic [2:0]  s_sfl, s_flout;
  logic [15:0] s_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then let the stack model react to
  // the push/pop that the edge commits.
  task automatic cyc();
    @(negedge clk);
    s_ack = ack;   s_stall = stall; s_rd = memory_read; s_wr = memory_write;
    s_push = memory_push; s_pop = memory_pop; s_asel = memory_address_select;
    s_wsrc = memory_write_src_select; s_spc = saved_pc; s_sfl = saved_flags;
    s_pcout = pc_out; s_flout = flags_out; s_pcv = pc_valid; s_flv = flags_valid;
    s_vl = vector_load; s_wd = wdata;
    @(posedge clk);
    #1;
    if (s_push) begin
      stk[sp] = s_wd;
      pushed_q.push_back(s_wd);
      sp = sp - 11'd1;
    end
    if (s_pop) sp = sp + 11'd1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(s_ack), 32'd0);
    chk({tag, "_stall"}, 32'(s_stall), 32'd0);
    chk({tag, "_memctl"}, 32'({s_rd, s_wr, s_push, s_pop}), 32'd0);
    chk({tag, "_sel"}, 32'({s_asel, s_wsrc}), 32'd0);
    chk({tag, "_saved_pc"}, s_spc, 32'd0);
    chk({tag, "_saved_fl"}, 32'(s_sfl), 32'd0);
    chk({tag, "_pc_out"}, s_pcout, 32'd0);
    chk({tag, "_fl_out"}, 32'(s_flout), 32'd0);
    chk({tag, "_pulses"}, 32'({s_pcv, s_flv, s_vl}), 32'd0);
  endtask

  task automatic idle_cyc(input string tag);
    cyc();
    chk({tag, "_ack"}, 32'(s_ack), 32'd0);
    chk({tag, "_stall"}, 32'(s_stall), 32'd0);
    chk({tag, "_memctl"}, 32'({s_rd, s_wr, s_push, s_pop, s_asel}), 32'd0);
    chk({tag, "_pulses"}, 32'({s_pcv, s_flv, s_vl}), 32'd0);
  endtask

  // One transaction from its accept cycle to its DONE cycle. drive=0 means
  // the request is already pending inside the DUT; int_k>=1 pulses interrupt
  // in that cycle of the sequence.
  task automatic run_op(input int op, input logic [31:0] pc, input logic [2:0] fl,
                        input bit drive, input int int_k);
    int          len, n_push, n_pop;
    logic [15:0] exp_push[$];
    logic [15:0] lo, hi, w;
    logic [2:0]  ef;
    bit          last;
    len    = (op == K_INT || op == K_RTI) ? 5 : 4;
    n_push = (op == K_INT) ? 3 : (op == K_CALL) ? 2 : 0;
    n_pop  = (op == K_RTI) ? 3 : (op == K_RET) ? 2 : 0;
    exp_push.delete();
    if (n_push > 0) begin
      exp_push.push_back(pc[31:16]);
      exp_push.push_back(pc[15:0]);
      if (op == K_INT) exp_push.push_back({13'h0, fl});
    end
    ef = 3'h0; lo = 16'h0; hi = 16'h0;
    if (op == K_RTI) begin
      w  = stk[sp + 11'd1];
      ef = w[2:0];
      lo = stk[sp + 11'd2];
      hi = stk[sp + 11'd3];
    end else if (op == K_RET) begin
      lo = stk[sp + 11'd1];
      hi = stk[sp + 11'd2];
    end
    pushed_q.delete();
    pc_in = pc; flags_in = fl;
    if (drive) begin
      case (op)
        K_INT:   interrupt = 1'b1;
        K_CALL:  call_req  = 1'b1;
        K_RET:   ret_req   = 1'b1;
        default: rti_req   = 1'b1;
      endcase
    end
    for (int k = 0; k < len; k++) begin
      if (k == int_k) interrupt = 1'b1;
      cyc();
      interrupt = 1'b0;
      if (k == 0 && drive) begin
        if (op == K_CALL) call_req = 1'b0;
        if (op == K_RET)  ret_req  = 1'b0;
        if (op == K_RTI)  rti_req  = 1'b0;
      end
      last = (k == len - 1);
      chk("ack", 32'(s_ack), 32'(k == 0));
      chk("stall", 32'(s_stall), 32'd1);
      chk("push_pop_excl", 32'(s_push & s_pop), 32'd0);
      chk("push", 32'({s_push, s_wr}), (k >= 1 && k <= n_push) ? 32'd3 : 32'd0);
      chk("pop", 32'({s_pop, s_rd}), (k >= 1 && k <= n_pop) ? 32'd3 : 32'd0);
      chk("asel", 32'(s_asel), (k >= 1 && k <= n_push + n_pop) ? 32'd2 : 32'd0);
      chk("pc_valid", 32'(s_pcv), 32'(last && (op == K_RET || op == K_RTI)));
      chk("flags_valid", 32'(s_flv), 32'(last && op == K_RTI));
      chk("vector_load", 32'(s_vl), 32'(last && op == K_INT));
      if (last && (op == K_RET || op == K_RTI)) chk("pc_out", s_pcout, {hi, lo});
      if (last && op == K_RTI) chk("flags_out", 32'(s_flout), 32'(ef));
    end
    chk("push_count", 32'(pushed_q.size()), 32'(exp_push.size()));
    for (int i = 0; i < exp_push.size() && i < pushed_q.size(); i++)
      chk("push_word", 32'(pushed_q[i]), 32'(exp_push[i]));
  endtask

  initial begin
    int          op, ik, len, gap;
    logic [10:0] sp0;
    for (int i = 0; i < 2048; i++) stk[i] = 16'h0;
    sp = 11'd1024;
    reset = 1'b1; interrupt = 1'b1; call_req = 1'b1; ret_req = 1'b0; rti_req = 1'b0;
    pc_in = 32'hDEAD_BEEF; flags_in = 3'b111;

    // Requests held during reset must not leak through.
    cyc(); check_all_zero("rst0");
    cyc(); check_all_zero("rst1");
    interrupt = 1'b0; call_req = 1'b0; reset = 1'b0;
    cyc(); check_all_zero("idle_after_rst");

    // Interrupt push sequence and vector load.
    run_op(K_INT, 32'h0001_2345, 3'b101, 1'b1, -1);
    chk("int_sp", 32'(sp), 32'd1021);
    idle_cyc("int_end");

    // Round trip through rti.
    run_op(K_RTI, 32'h0000_0000, 3'b000, 1'b1, -1);
    idle_cyc("rti_end");
    chk("rti_pc", s_pcout, 32'h0001_2345);
    chk("rti_flags", 32'(s_flout), 32'd5);
    chk("rti_sp", 32'(sp), 32'd1024);

    // ret with known words on the stack.
    stk[11'd1025] = 16'hBEEF;
    stk[11'd1026] = 16'h00CA;
    run_op(K_RET, 32'h1111_2222, 3'b010, 1'b1, -1);
    idle_cyc("ret_end");
    chk("ret_pc", s_pcout, 32'h00CA_BEEF);
    sp = 11'd1024;

    // Interrupt during a call's PUSH_LO is taken right after the call's DONE.
    run_op(K_CALL, 32'hA5A5_0F0F, 3'b011, 1'b1, 2);
    run_op(K_INT, 32'h7777_8888, 3'b110, 1'b0, -1);
    idle_cyc("int_pend_end");

    // Simultaneous interrupt and ret: interrupt first, ret held and taken next.
    ret_req = 1'b1;
    run_op(K_INT, 32'h0BAD_F00D, 3'b001, 1'b1, -1);
    run_op(K_RET, 32'h0, 3'b000, 1'b1, -1);
    idle_cyc("int_ret_end");

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      op  = int'($urandom_range(0, 3));
      len = (op == K_INT || op == K_RTI) ? 5 : 4;
      ik  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      run_op(op, $urandom, 3'($urandom_range(0, 7)), 1'b1, ik);
      if (ik >= 0) run_op(K_INT, $urandom, 3'($urandom_range(0, 7)), 1'b0, -1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cyc("rand_gap");
    end
    idle_cyc("pre_abort");

    // Reset during POP_LO aborts the ret with no pc_valid.
    sp0 = sp;
    ret_req = 1'b1;
    cyc();
    chk("abort_ack", 32'(s_ack), 32'd1);
    ret_req = 1'b0;
    reset = 1'b1;
    cyc(); check_all_zero("abort_in_rst");
    reset = 1'b0;
    cyc(); check_all_zero("abort_next");
    cyc(); check_all_zero("abort_next2");
    chk("abort_sp", 32'(sp), 32'(sp0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
